rv32_mem_responder: RTL
=======================

Name: rv32_mem_responder

Overview:
- Word-addressed data-memory responder serving the priRV32 core's load/store request port; it is the slave end of the core's memory request/response handshake.
- Accepts one request at a time, performs the read or byte-strobed write after a configurable wait-state delay, and returns a response.
- Flags misaligned and out-of-range accesses with an error response.
- Used both as the core's on-chip data RAM and as the bus model in core-level benches.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage; power of two, minimum 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_CYCLES, 1: extra cycles between request acceptance and response; range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  when low, no new request is accepted; an in-flight transaction still completes.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder accepts a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte-lane write enables; bit i covers bits 8i+7:8i.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access fault (misaligned or out of range).

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter = 0.
  - Memory contents are not cleared.
  - Reset mid-transaction abandons the transaction: a store not yet committed is never written, and no response is produced.
- FSM states: IDLE, WAIT, RESP.
- req_ready = enable AND (state==IDLE), combinational from state and enable only. It never depends on req_valid.
- Accept = req_valid AND req_ready at a rising edge. On accept, latch req_we, req_addr, req_wdata and req_wstrb.
  - WAIT_CYCLES==0: go directly to RESP.
  - Otherwise: load counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: counter decrements each cycle; at the edge where counter==0, go to RESP.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 clocks after the accept edge.
- Commit (on the edge entering RESP):
  - Fault check: fault = (addr[1:0]!=0) OR (addr < BASE_ADDR) OR (addr >= BASE_ADDR + DEPTH_WORDS*4). Compute the bounds at 33-bit width so there is no wrap-around.
  - Fault: no memory access; rsp_err=1, rsp_rdata=0.
  - Load: rsp_rdata = mem[(addr-BASE_ADDR)>>2]; rsp_err=0.
  - Store: each byte lane with wstrb[i]=1 is updated; rsp_rdata=0, rsp_err=0.
  - wstrb=4'b0000 store: no memory change, normal response.
  - req_wstrb is ignored for loads.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_valid AND rsp_ready.
  - On that handshake edge: go to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Exactly one outstanding transaction. req_ready is low in WAIT and RESP, so there is no overlap of a new request with a pending response. Minimum request spacing is WAIT_CYCLES+2 clocks.
- enable low:
  - Blocks acceptance only.
  - The WAIT counter keeps running and RESP keeps waiting for rsp_ready.
  - enable dropping in the same cycle as req_valid means no accept.
- rsp_ready held high before rsp_valid has no effect; the response still appears at the fixed latency and completes in its first cycle.
- Inputs other than the handshake are sampled only at the accept edge; changes afterwards do not affect the transaction.

Test Plan:
1. Reset values:
   - Stimulus: reset low for 15 ns, enable=1.
   - Required: rsp_valid=0, rsp_rdata=0, rsp_err=0 during reset. After release, req_ready=1 at the next edge.
2. Store then load, WAIT_CYCLES=1:
   - Stimulus: store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF; then load 0x10 with rsp_ready=1.
   - Required: store rsp_valid exactly 2 clocks after accept, rsp_err=0. Load returns 0xDEADBEEF, 2 clocks after its accept.
3. Byte strobes:
   - Stimulus: after test 2, store 0x10 wdata 0x11223344 wstrb 4'b0101; then load 0x10.
   - Required: load returns 0xDE22BE44.
4. Faults:
   - Stimulus: load 0x12; store to BASE_ADDR+DEPTH_WORDS*4; load 0xFFFF_FFFC.
   - Required: each gives rsp_err=1, rsp_rdata=0. No memory word changes (verified by reading back all previously written words).
5. Backpressure and enable:
   - Stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid rises; toggle req_valid and enable during that time.
   - Required: rsp_rdata and rsp_err stable and req_ready=0 throughout. Response completes on the rsp_ready edge. Next accept only when enable=1 and the FSM is in IDLE.
6. Reset mid-operation:
   - Stimulus: WAIT_CYCLES=3; accept store 0x20 wdata 0xCAFEF00D; assert reset one clock after accept; release; load 0x20.
   - Required: no response for the abandoned store. Load returns the pre-store value of address 0x20.

Source files
------------

// File: rtl/rv32_mem_responder.sv
// rv32_mem_responder: single-outstanding data-memory responder for the
// priRV32 load/store port. It accepts one request, waits WAIT_CYCLES, commits
// the read or byte-strobed write, then holds the response until the core takes it.
module rv32_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned LP_AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LP_BASE     = {1'b0, BASE_ADDR};
    localparam logic [32:0] LP_SIZE     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LP_CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_req_ready;
    logic             w_accept;
    logic             w_live;
    logic             w_commit;
    logic             w_we;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [3:0]       w_wstrb;
    logic [32:0]      w_rel;
    logic             w_fault;
    logic [LP_AW-1:0] w_idx;

    assign w_accept = req_valid && w_req_ready;

    // With zero wait states the commit happens on the accept edge itself, so
    // the transaction fields come straight from the request port while IDLE.
    assign w_live  = (r_state == S_IDLE);
    assign w_we    = w_live ? req_we    : r_we;
    assign w_addr  = w_live ? req_addr  : r_addr;
    assign w_wdata = w_live ? req_wdata : r_wdata;
    assign w_wstrb = w_live ? req_wstrb : r_wstrb;

    // Commit is the edge that enters RESP. Qualifying it with reset keeps a
    // store from landing in memory while reset is held, since req_ready is
    // allowed to be high in IDLE during reset.
    assign w_commit = reset &&
                      ((w_live && w_accept && (WAIT_CYCLES == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd0)));

    // 33-bit offset: an address below BASE_ADDR wraps into bit 32 and so
    // compares as out of range together with addresses past the top.
    assign w_rel   = {1'b0, w_addr} - LP_BASE;
    assign w_fault = (w_addr[1:0] != 2'b00) || (w_rel >= LP_SIZE);
    assign w_idx   = w_rel[LP_AW+1:2];

    // State register
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: acceptance depends only on enable and state, never on req_valid
    always_comb begin
        w_req_ready = enable && (r_state == S_IDLE);
        rsp_valid   = (r_state == S_RESP);
    end

    assign req_ready = w_req_ready;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // Request capture on accept; fields are ignored afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_live && w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    // Wait-state counter: loaded on accept, counts down to zero in WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
        end else if (w_live && w_accept) begin
            r_cnt <= LP_CNT_INIT;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response registers: set at commit, held through RESP, cleared on handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_fault;
            r_rdata <= (!w_fault && !w_we) ? r_mem[w_idx] : '0;
        end else if ((r_state == S_RESP) && rsp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

    // Storage array with per-byte-lane writes at commit
    // NOTE: the memory array has no reset; contents survive reset and map to plain RAM.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
